// File: rtl/nav_pkg.sv
// Shared types and step-legality helpers for the robot navigation controller.
package nav_pkg;

    localparam int K_DEF = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NAV,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    // Up increments y, right increments x; grid is 0..3k-1 on both axes.
    function automatic logic in_grid(input int x, input int y, input dir_t d, input int k);
        logic ok;
        case (d)
            DIR_UP:   ok = (y + 1 <= 3 * k - 1);
            DIR_DOWN: ok = (y >= 1);
            DIR_LEFT: ok = (x >= 1);
            default:  ok = (x + 1 <= 3 * k - 1);
        endcase
        return ok;
    endfunction

    // Wall A closes column k-1/k below row 2k; wall B closes column 2k-1/2k from row 2k up.
    function automatic logic wall_ok(input int x, input int y, input dir_t d, input int k);
        logic ok;
        case (d)
            DIR_RIGHT: ok = !(((x == k - 1) && (y < 2 * k)) || ((x == 2 * k - 1) && (y >= 2 * k)));
            DIR_LEFT:  ok = !(((x == k) && (y < 2 * k)) || ((x == 2 * k) && (y >= 2 * k)));
            default:   ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/nav_step_sel.sv
// Combinational next-step chooser: horizontal first, detouring vertically around the walls.
module nav_step_sel
    import nav_pkg::*;
#(
    parameter int K       = K_DEF,
    parameter int COORD_W = 4
) (
    input  logic [COORD_W-1:0] i_pos_x,
    input  logic [COORD_W-1:0] i_pos_y,
    input  logic [COORD_W-1:0] i_goal_x,
    input  logic [COORD_W-1:0] i_goal_y,
    output logic [1:0]         o_dir,
    output logic               o_legal,
    output logic               o_at_goal,
    output logic [COORD_W-1:0] o_tgt_x,
    output logic [COORD_W-1:0] o_tgt_y
);

    dir_t w_dir;
    dir_t w_h_dir;
    int   w_x;
    int   w_y;
    logic w_at_goal;

    assign w_x = int'(i_pos_x);
    assign w_y = int'(i_pos_y);

    always_comb begin
        w_h_dir   = (i_goal_x > i_pos_x) ? DIR_RIGHT : DIR_LEFT;
        w_dir     = DIR_UP;
        w_at_goal = 1'b0;
        if (i_pos_x != i_goal_x) begin
            if (in_grid(w_x, w_y, w_h_dir, K) && wall_ok(w_x, w_y, w_h_dir, K))
                w_dir = w_h_dir;
            // Blocked crossing: wall A opens above, wall B opens below.
            else if (((w_h_dir == DIR_RIGHT) ? w_x : w_x - 1) == K - 1)
                w_dir = DIR_UP;
            else
                w_dir = DIR_DOWN;
        end else if (i_pos_y != i_goal_y) begin
            w_dir = (i_goal_y > i_pos_y) ? DIR_UP : DIR_DOWN;
        end else begin
            w_at_goal = 1'b1;
        end
    end

    always_comb begin
        o_tgt_x = i_pos_x;
        o_tgt_y = i_pos_y;
        case (w_dir)
            DIR_UP:   o_tgt_y = i_pos_y + COORD_W'(1);
            DIR_DOWN: o_tgt_y = i_pos_y - COORD_W'(1);
            DIR_LEFT: o_tgt_x = i_pos_x - COORD_W'(1);
            default:  o_tgt_x = i_pos_x + COORD_W'(1);
        endcase
    end

    assign o_dir     = w_dir;
    assign o_at_goal = w_at_goal;
    assign o_legal   = !w_at_goal && in_grid(w_x, w_y, w_dir, K) && wall_ok(w_x, w_y, w_dir, K);

endmodule

// File: rtl/robot_nav_ctrl.sv
// Closed-loop robot driver: goal handshake, shadow position, one move per cycle with obstacle exclusion.
// Define NAV_OBS_AVOID_EN to add the target-cell obstacle WAIT state and abort.
module robot_nav_ctrl
    import nav_pkg::*;
#(
    parameter int K        = K_DEF,
    parameter int COORD_W  = 4,
    parameter int WAIT_MAX = 7
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_run,
    input  logic               i_goal_valid,
    output logic               o_goal_ready,
    input  logic [COORD_W-1:0] i_goal_x,
    input  logic [COORD_W-1:0] i_goal_y,
    input  logic               i_obs_active,
    input  logic [COORD_W-1:0] i_obs_x,
    input  logic [COORD_W-1:0] i_obs_y,
    input  logic               i_err,
    output logic               o_move_robot,
    output logic               o_ctl_up,
    output logic               o_ctl_down,
    output logic               o_ctl_left,
    output logic               o_ctl_right,
    output logic [COORD_W-1:0] o_pos_x,
    output logic [COORD_W-1:0] o_pos_y,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_abort,
    output logic               o_goal_err,
    output logic               o_fault
);

    localparam logic [COORD_W-1:0] MAX_C = COORD_W'(3 * K - 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_run;
    logic [COORD_W-1:0] r_pos_x;
    logic [COORD_W-1:0] r_pos_y;
    logic [COORD_W-1:0] r_goal_x;
    logic [COORD_W-1:0] r_goal_y;
    logic [1:0]         w_dir_raw;
    dir_t               w_dir;
    logic               w_legal;
    logic               w_at_goal;
    logic [COORD_W-1:0] w_tgt_x;
    logic [COORD_W-1:0] w_tgt_y;
    logic               w_accept;
    logic               w_goal_bad;
    logic               w_tgt_obs;
    logic               w_tgt_is_goal;
    logic               w_move;
    logic               w_wait_expired;

    nav_step_sel #(.K(K), .COORD_W(COORD_W)) u_step (
        .i_pos_x   (r_pos_x),
        .i_pos_y   (r_pos_y),
        .i_goal_x  (r_goal_x),
        .i_goal_y  (r_goal_y),
        .o_dir     (w_dir_raw),
        .o_legal   (w_legal),
        .o_at_goal (w_at_goal),
        .o_tgt_x   (w_tgt_x),
        .o_tgt_y   (w_tgt_y)
    );

    assign w_dir         = dir_t'(w_dir_raw);
    assign w_goal_bad    = (i_goal_x > MAX_C) || (i_goal_y > MAX_C);
    assign w_accept      = i_goal_valid && r_run && (r_state == S_IDLE);
    assign w_tgt_is_goal = (w_tgt_x == r_goal_x) && (w_tgt_y == r_goal_y);
    // Exclusion inputs gate the request combinationally so it drops in the same cycle.
    assign w_move        = (r_state == S_NAV) && w_legal && !w_tgt_obs && !i_obs_active && !i_err;

`ifdef NAV_OBS_AVOID_EN
    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    logic [CNT_W-1:0] r_cnt;

    assign w_tgt_obs      = w_legal && (w_tgt_x == i_obs_x) && (w_tgt_y == i_obs_y);
    assign w_wait_expired = (r_state == S_WAIT) && (r_cnt == CNT_W'(WAIT_MAX));

    // The NAV cycle that first sees the blockage counts as blocked cycle one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (w_next != S_WAIT)
            r_cnt <= '0;
        else if (r_state != S_WAIT)
            r_cnt <= CNT_W'(1);
        else if (!i_obs_active)
            r_cnt <= r_cnt + CNT_W'(1);
    end
`else
    logic w_unused_obs;
    assign w_tgt_obs      = 1'b0;
    assign w_wait_expired = 1'b0;
    assign w_unused_obs   = (^{i_obs_x, i_obs_y}) ^ (WAIT_MAX == 0);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_goal_bad)
                    w_next = ((i_goal_x == r_pos_x) && (i_goal_y == r_pos_y)) ? S_DONE : S_NAV;
            end
            S_NAV: begin
                if (w_at_goal || (w_move && w_tgt_is_goal))
                    w_next = S_DONE;
                else if (w_tgt_obs && !i_obs_active)
                    w_next = S_WAIT;
            end
`ifdef NAV_OBS_AVOID_EN
            S_WAIT: begin
                if (w_wait_expired)
                    w_next = S_IDLE;
                else if (!i_obs_active && !w_tgt_obs)
                    w_next = S_NAV;
            end
`endif
            S_DONE:  w_next = S_IDLE;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_IDLE;
        endcase
        if (i_err)
            w_next = S_FAULT;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_run    <= 1'b0;
            r_pos_x  <= '0;
            r_pos_y  <= '0;
            r_goal_x <= '0;
            r_goal_y <= '0;
        end else begin
            if (i_run)
                r_run <= 1'b1;
            if (w_accept && !w_goal_bad) begin
                r_goal_x <= i_goal_x;
                r_goal_y <= i_goal_y;
            end
            if (w_move) begin
                r_pos_x <= w_tgt_x;
                r_pos_y <= w_tgt_y;
            end
        end
    end

    always_comb begin
        o_goal_ready = r_run && (r_state == S_IDLE);
        o_move_robot = w_move;
        o_ctl_up     = w_move && (w_dir == DIR_UP);
        o_ctl_down   = w_move && (w_dir == DIR_DOWN);
        o_ctl_left   = w_move && (w_dir == DIR_LEFT);
        o_ctl_right  = w_move && (w_dir == DIR_RIGHT);
        o_busy       = (r_state == S_NAV) || (r_state == S_WAIT);
        o_done       = (r_state == S_DONE);
        o_abort      = w_wait_expired;
        o_goal_err   = w_accept && w_goal_bad;
        o_fault      = (r_state == S_FAULT);
    end

    assign o_pos_x = r_pos_x;
    assign o_pos_y = r_pos_y;

endmodule

// File: tb/tb_robot_nav_ctrl.sv
// Directed self-checking bench for robot_nav_ctrl with K=2 (6x6 grid).
module tb_robot_nav_ctrl;

    logic       clk, rst, run, goal_valid, goal_ready, obs_active, err;
    logic [3:0] goal_x, goal_y, obs_x, obs_y, pos_x, pos_y;
    logic       move_robot, ctl_up, ctl_down, ctl_left, ctl_right;
    logic       busy, done, abort, goal_err, fault;
    logic [3:0] ctl;
    int         n_pass, n_total;

    localparam logic [3:0] U = 4'b1000, D = 4'b0100, L = 4'b0010, R = 4'b0001;

    assign ctl = {ctl_up, ctl_down, ctl_left, ctl_right};

    robot_nav_ctrl #(.K(2), .COORD_W(4), .WAIT_MAX(7)) dut (
        .i_clk(clk), .i_rst(rst), .i_run(run),
        .i_goal_valid(goal_valid), .o_goal_ready(goal_ready),
        .i_goal_x(goal_x), .i_goal_y(goal_y),
        .i_obs_active(obs_active), .i_obs_x(obs_x), .i_obs_y(obs_y),
        .i_err(err),
        .o_move_robot(move_robot), .o_ctl_up(ctl_up), .o_ctl_down(ctl_down),
        .o_ctl_left(ctl_left), .o_ctl_right(ctl_right),
        .o_pos_x(pos_x), .o_pos_y(pos_y),
        .o_busy(busy), .o_done(done), .o_abort(abort),
        .o_goal_err(goal_err), .o_fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1; run = 0; goal_valid = 0; obs_active = 0; err = 0;
        @(posedge clk); #1 rst = 0; run = 1;
        @(posedge clk); #1 run = 0;
    endtask

    task automatic accept_goal(input logic [3:0] x, input logic [3:0] y);
        goal_x = x; goal_y = y; goal_valid = 1;
        @(posedge clk); #1 goal_valid = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++;
        if ({goal_ready, move_robot, ctl, busy, done, abort, goal_err, fault} !== 11'd0)
            $display("FAIL reset_outputs: got %b expected 0", {goal_ready, move_robot, ctl, busy, done, abort, goal_err, fault});
        else n_pass++;
        n_total++;
        if ({pos_x, pos_y} !== 8'h00) $display("FAIL reset_pos: got %h expected 00", {pos_x, pos_y});
        else n_pass++;
    endtask

    task automatic test_no_run();
        int seen;
        seen = 0;
        @(posedge clk); #1 rst = 0;
        goal_x = 1; goal_y = 0; goal_valid = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (goal_ready || busy || move_robot) seen++;
            @(posedge clk); #1;
        end
        goal_valid = 0;
        n_total++;
        if (seen !== 0) $display("FAIL no_run_accept: got %0d active cycles expected 0", seen);
        else n_pass++;
        run = 1; @(posedge clk); #1 run = 0;
        @(negedge clk);
        n_total++;
        if ({goal_ready, pos_x, pos_y} !== 9'h100) $display("FAIL run_sticky: got %h expected 100", {goal_ready, pos_x, pos_y});
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_route();
        logic [3:0] exp_seq [13];
        int moves, done_cyc, done_cnt, bad_hot;
        logic busy_c1;
        exp_seq = '{R, U, U, U, U, R, R, D, R, R, D, D, D};
        moves = 0; done_cyc = 0; done_cnt = 0; bad_hot = 0; busy_c1 = 0;
        accept_goal(5, 0);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) busy_c1 = busy;
            if (move_robot) begin
                if (moves < 13) begin
                    n_total++;
                    if (ctl !== exp_seq[moves]) $display("FAIL route_dir%0d: got %b expected %b", moves, ctl, exp_seq[moves]);
                    else n_pass++;
                end
                if (!(ctl == U || ctl == D || ctl == L || ctl == R)) bad_hot++;
                moves++;
            end else if (ctl !== 4'b0000) bad_hot++;
            if (done) begin
                if (done_cnt == 0) done_cyc = c;
                done_cnt++;
            end
            @(posedge clk); #1;
        end
        n_total++;
        if (moves !== 13) $display("FAIL route_moves: got %0d expected 13", moves); else n_pass++;
        n_total++;
        if (done_cyc !== 14) $display("FAIL route_done_cycle: got %0d expected 14", done_cyc); else n_pass++;
        n_total++;
        if (done_cnt !== 1) $display("FAIL route_done_pulses: got %0d expected 1", done_cnt); else n_pass++;
        n_total++;
        if ({pos_x, pos_y} !== 8'h50) $display("FAIL route_pos: got %h expected 50", {pos_x, pos_y}); else n_pass++;
        n_total++;
        if (busy_c1 !== 1'b1) $display("FAIL route_busy: got %b expected 1", busy_c1); else n_pass++;
        n_total++;
        if (bad_hot !== 0) $display("FAIL route_onehot: got %0d bad cycles expected 0", bad_hot); else n_pass++;
    endtask

    task automatic test_goal_err();
        int bad;
        bad = 0;
        goal_x = 6; goal_y = 0; goal_valid = 1;
        @(negedge clk);
        n_total++;
        if ({goal_ready, goal_err} !== 2'b11) $display("FAIL goal_err_x: got %b expected 11", {goal_ready, goal_err});
        else n_pass++;
        @(posedge clk); #1 goal_x = 0; goal_y = 6;
        @(negedge clk);
        n_total++;
        if ({busy, goal_err} !== 2'b01) $display("FAIL goal_err_y: got %b expected 01", {busy, goal_err});
        else n_pass++;
        @(posedge clk); #1 goal_valid = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (move_robot || busy || goal_err || !goal_ready) bad++;
            @(posedge clk); #1;
        end
        n_total++;
        if ({bad[3:0], pos_x, pos_y} !== 12'h050) $display("FAIL goal_err_idle: got %h expected 050", {bad[3:0], pos_x, pos_y});
        else n_pass++;
    endtask

    task automatic test_same_goal();
        accept_goal(5, 0);
        @(negedge clk);
        n_total++;
        if ({done, move_robot, busy} !== 3'b100) $display("FAIL same_goal_done: got %b expected 100", {done, move_robot, busy});
        else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++;
        if ({done, goal_ready, pos_x, pos_y} !== 10'h50 + 10'h100) $display("FAIL same_goal_after: got %h expected 150", {done, goal_ready, pos_x, pos_y});
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid_route();
        accept_goal(0, 0);
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({move_robot, ctl, pos_x, pos_y} !== {1'b1, U, 8'h20}) $display("FAIL mid_route_state: got %h expected %h", {move_robot, ctl, pos_x, pos_y}, {1'b1, U, 8'h20});
        else n_pass++;
        rst = 1;
        #1;
        n_total++;
        if ({goal_ready, move_robot, ctl, busy, done, abort, goal_err, fault, pos_x, pos_y} !== 19'd0)
            $display("FAIL rst_async: got %h expected 0", {goal_ready, move_robot, ctl, busy, done, abort, goal_err, fault, pos_x, pos_y});
        else n_pass++;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        n_total++;
        if ({goal_ready, busy} !== 2'b00) $display("FAIL rst_run_cleared: got %b expected 00", {goal_ready, busy});
        else n_pass++;
        @(posedge clk); #1 run = 1;
        @(posedge clk); #1 run = 0;
        @(negedge clk);
        n_total++;
        if ({goal_ready, busy, pos_x, pos_y} !== 10'h200) $display("FAIL rst_idle: got %h expected 200", {goal_ready, busy, pos_x, pos_y});
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int moves, stall_moves, done_cyc;
        logic move_c8;
        moves = 0; stall_moves = 0; done_cyc = 0; move_c8 = 0;
        accept_goal(5, 0);
        for (int c = 1; c <= 25; c++) begin
            obs_active = (c >= 3 && c <= 7);
            @(negedge clk);
            if (move_robot) begin
                moves++;
                if (c >= 3 && c <= 7) stall_moves++;
            end
            if (c == 8) move_c8 = move_robot;
            if (done && done_cyc == 0) done_cyc = c;
            @(posedge clk); #1;
        end
        obs_active = 0;
        n_total++;
        if (stall_moves !== 0) $display("FAIL stall_excl: got %0d moves expected 0", stall_moves); else n_pass++;
        n_total++;
        if (moves !== 13) $display("FAIL stall_moves: got %0d expected 13", moves); else n_pass++;
        n_total++;
        if (done_cyc !== 19) $display("FAIL stall_done_cycle: got %0d expected 19", done_cyc); else n_pass++;
        n_total++;
        if ({move_c8, pos_x, pos_y} !== 9'h150) $display("FAIL stall_resume_pos: got %h expected 150", {move_c8, pos_x, pos_y}); else n_pass++;
    endtask

    task automatic test_obstacle();
        int moves, abort_cyc, abort_cnt, done_cyc;
        logic busy_c4;
        moves = 0; abort_cyc = 0; abort_cnt = 0; done_cyc = 0; busy_c4 = 0;
        do_reset();
        obs_x = 0; obs_y = 1;
        accept_goal(0, 2);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (move_robot) moves++;
            if (abort) begin
                if (abort_cnt == 0) abort_cyc = c;
                abort_cnt++;
            end
            if (done && done_cyc == 0) done_cyc = c;
            if (c == 4) busy_c4 = busy;
            @(posedge clk); #1;
        end
        obs_x = 15; obs_y = 15;
`ifdef NAV_OBS_AVOID_EN
        n_total++;
        if (moves !== 0) $display("FAIL obs_moves: got %0d expected 0", moves); else n_pass++;
        n_total++;
        if ({abort_cyc, abort_cnt} !== {32'd8, 32'd1}) $display("FAIL obs_abort: got cycle %0d count %0d expected cycle 8 count 1", abort_cyc, abort_cnt);
        else n_pass++;
        n_total++;
        if (busy_c4 !== 1'b1) $display("FAIL obs_wait_busy: got %b expected 1", busy_c4); else n_pass++;
        n_total++;
        if ({goal_ready, pos_x, pos_y} !== 9'h100) $display("FAIL obs_after: got %h expected 100", {goal_ready, pos_x, pos_y});
        else n_pass++;
`else
        n_total++;
        if (moves !== 2) $display("FAIL obs_ignored_moves: got %0d expected 2", moves); else n_pass++;
        n_total++;
        if (abort_cnt !== 0) $display("FAIL obs_abort_tied: got %0d expected 0", abort_cnt); else n_pass++;
        n_total++;
        if (done_cyc !== 3) $display("FAIL obs_ignored_done: got %0d expected 3", done_cyc); else n_pass++;
        n_total++;
        if ({goal_ready, pos_x, pos_y} !== 9'h102) $display("FAIL obs_ignored_pos: got %h expected 102", {goal_ready, pos_x, pos_y});
        else n_pass++;
        n_total++;
        if (busy_c4 !== 1'b0) $display("FAIL obs_ignored_busy: got %b expected 0", busy_c4); else n_pass++;
`endif
    endtask

    task automatic test_err();
        int moves, fault_first, fault_cnt;
        logic move_c6;
        moves = 0; fault_first = 0; fault_cnt = 0; move_c6 = 1;
        do_reset();
        accept_goal(5, 0);
        for (int c = 1; c <= 12; c++) begin
            err = (c == 6);
            @(negedge clk);
            if (move_robot) moves++;
            if (c == 6) move_c6 = move_robot;
            if (fault) begin
                if (fault_cnt == 0) fault_first = c;
                fault_cnt++;
            end
            @(posedge clk); #1;
        end
        err = 0;
        n_total++;
        if (move_c6 !== 1'b0) $display("FAIL err_suppress: got %b expected 0", move_c6); else n_pass++;
        n_total++;
        if (moves !== 5) $display("FAIL err_moves: got %0d expected 5", moves); else n_pass++;
        n_total++;
        if ({fault_first, fault_cnt} !== {32'd7, 32'd6}) $display("FAIL err_fault_sticky: got first %0d count %0d expected first 7 count 6", fault_first, fault_cnt);
        else n_pass++;
        n_total++;
        if ({goal_ready, busy, pos_x, pos_y} !== 10'h014) $display("FAIL err_state: got %h expected 014", {goal_ready, busy, pos_x, pos_y});
        else n_pass++;
        rst = 1;
        #1;
        n_total++;
        if ({fault, pos_x, pos_y} !== 9'h000) $display("FAIL err_rst_clear: got %h expected 000", {fault, pos_x, pos_y});
        else n_pass++;
        @(posedge clk); #1 rst = 0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1; run = 0; goal_valid = 0; goal_x = 0; goal_y = 0;
        obs_active = 0; obs_x = 15; obs_y = 15; err = 0;
        test_reset();
        test_no_run();
        test_route();
        test_goal_err();
        test_same_goal();
        test_rst_mid_route();
        test_stall();
        test_obstacle();
        test_err();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
